// File: rtl/data_mem_resp_if.sv
// Memory-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface data_mem_resp_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, done, stall, err
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, done, stall, err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory responder: one access in flight, stall while busy,
// one-cycle done pulse. Optional memory dump gated by DATA_MEM_RESP_DUMP_EN.
module data_mem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
`ifdef DATA_MEM_RESP_DUMP_EN
  input  logic           createdump,
`endif
  data_mem_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

  stateT         stateReg, stateNext;
  logic [CW-1:0] cntReg, cntNext;
  logic          accept, respEntry;

  logic          wrReg;
  logic          oddReg;
  logic [AW-1:0] wordReg;
  logic [15:0]   dataReg;

  logic [15:0]   dataOutReg;
  logic          doneReg;
  logic          errReg;

  logic [15:0]   mem [DEPTH];

  // BUSY holds for LATENCY cycles, so RESP is entered on edge E0+LATENCY.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    accept    = 1'b0;
    respEntry = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (bus.enable) begin
          accept    = 1'b1;
          stateNext = BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cntReg == '0) begin
          stateNext = RESP;
          respEntry = 1'b1;
        end else begin
          cntNext = cntReg - CW'(1);
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      wrReg      <= 1'b0;
      oddReg     <= 1'b0;
      wordReg    <= '0;
      dataReg    <= '0;
      dataOutReg <= '0;
      doneReg    <= 1'b0;
      errReg     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      doneReg  <= respEntry;
      errReg   <= respEntry && oddReg;
      if (accept) begin
        wrReg   <= bus.wr;
        oddReg  <= bus.addr[0];
        wordReg <= bus.addr[AW:1];
        dataReg <= bus.data_in;
      end
      // Stores keep the previous read data; unaligned accesses return zero.
      if (respEntry && oddReg) begin
        dataOutReg <= '0;
      end else if (respEntry && !wrReg) begin
        dataOutReg <= mem[wordReg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (respEntry && wrReg && !oddReg) begin
      mem[wordReg] <= dataReg;
    end
  end

  generate
    if (AW < 15) begin : gUnusedAddr
      logic unusedAddrBits;
      assign unusedAddrBits = ^bus.addr[15:AW+1];
    end
  endgenerate

  assign bus.stall    = (stateReg != IDLE);
  assign bus.done     = doneReg;
  assign bus.err      = errReg;
  assign bus.data_out = dataOutReg;

`ifdef DATA_MEM_RESP_DUMP_EN
  always @(posedge clk) begin
    if (rst && createdump && stateReg == IDLE) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem[i] != '0) $display("%h %h", 16'(2 * i), mem[i]);
      end
    end
  end
`endif
endmodule
